id_ex_stage_register: RTL and testbench
=======================================

// Module: id_ex_stage_register
// PURPOSE
//  ID/EX pipeline register of the 5-stage RISC-V core; captures decode-stage control bundle + operands each cycle.
//  Detects load-use hazards (stall 1 cycle, insert bubble), squashes on branch/jump flush, and filters illegal opcodes.
//  Provides a saturating stall counter for performance checks.
// PARAMETERS
//  DATA_WIDTH      32  width of PC, register operands, immediate
//  REG_ADDR_WIDTH  5   register index width
//  CNT_WIDTH       16  stall counter width
// PORTS
//  clk              in   1    core clock, rising edge
//  reset            in   1    asynchronous, active-high reset
//  Valid_i          in   1    ID stage holds a real instruction
//  Flush_i          in   1    EX resolved taken branch/jump; squash ID contents
//  PC_i             in   DW   PC of decode instruction
//  Read_Data_1_i    in   DW   rs1 value from register file
//  Read_Data_2_i    in   DW   rs2 value from register file
//  Immediate_i      in   DW   sign-extended immediate
//  Rs1_i/Rs2_i/Rd_i in   RAW  source/destination indices
//  Funct_i          in   4    {funct7[5], funct3}
//  Branch_i, Mem_Read_i, Mem_to_Reg_i, Mem_Write_i, ALU_Src_i, Reg_Write_i  in 1  decode control
//  ALU_Op_i         in   3    decode ALU class
//  Stall_o          out  1    combinational; freeze PC and IF/ID this cycle
//  *_o (all above data/control fields + Valid_o)  out  same widths  registered EX-stage copies
//  Illegal_o        out  1    sticky: illegal encoding entered ID while valid
//  Stall_Count_o    out  CNT  saturating count of load-use stalls
// BEHAVIOUR
//  Reset: every registered output = 0 (bubble), Illegal_o=0, Stall_Count_o=0; async assert, sync release.
//  Latency: 1 cycle ID->EX; no backpressure from downstream.
//  Source use from ALU_Op_i: 000 R rs1+rs2; 001 I rs1; 010 U none; 011 load rs1; 100 S rs1+rs2;
//   101 SB rs1+rs2; 110 J none; 111 JALR rs1.
//  Illegal = Valid_i & Mem_Read_i & Mem_Write_i (decode default encoding drives all ones); never loaded, bubble instead.
//  Load-use: Stall_o = Valid_o & Mem_Read_o & (Rd_o!=0) & Valid_i & ~Flush_i &
//   ((use_rs1 & Rs1_i==Rd_o) | (use_rs2 & Rs2_i==Rd_o)).
//  Per-edge priority: reset > Flush_i > Stall_o > Illegal > Valid_i=0 > load.
//   Flush/Stall/Illegal/invalid: load bubble = all control 0, Valid_o=0, Rd_o=Rs1_o=Rs2_o=0, data fields 0.
//   Load: all *_o <= *_i, Valid_o<=1.
//  Stall lasts exactly 1 cycle (the bubble clears Mem_Read_o); counter +1 per stall cycle, holds at all ones.
//  Illegal_o sets on illegal cycle unless Flush_i is asserted the same cycle; it clears only on reset.
//  Rd=x0 loads never stall. Flush coincident with stall: flush wins, Stall_o=0, no count.
//  Reset mid-stall: outputs to bubble immediately, Stall_o drops with Valid_o.
// STRUCTURE
//  Shared package: ALU_Op class codes (R,I_LOGIC,U,LOAD,S,SB,J,JALR), control-bundle struct width 9.
//  Sub-module: id_ex_hazard_detect (combinational use-decode + compare -> Stall_o); the rest is flat register logic.
// TESTING
//  Reset held, then released with Valid_i=1 R-type -> all outputs 0 before release; fields appear at 1st edge after release.
//  lw x5 then add x6,x5,x1 -> Stall_o=1 one cycle, EX bubble (Valid_o=0), add loads next edge, Stall_Count_o=1.
//  lw x0 then add x6,x0,x0 -> Stall_o=0, no bubble; lui x7 after lw x7 -> no stall (U uses none).
//  Flush_i=1 with valid sw in ID -> next cycle Mem_Write_o=0, Valid_o=0; flush during load-use -> Stall_o=0.
//  Illegal opcode (controls all ones) valid -> bubble, Illegal_o=1 sticky until reset; with Flush_i -> Illegal_o stays 0.
//  CNT_WIDTH=2, four load-use stalls -> Stall_Count_o saturates at 3.

Source files
------------

// File: rtl/id_ex_stage_register_pkg.sv
// Shared definitions for the ID/EX pipeline register.
//   alu_op_e  : decode ALU class codes carried in ALU_Op
//   ctrl_t    : 9-bit decode control bundle registered into EX
//   uses_rs1 / uses_rs2 : which source registers an ALU class actually reads,
//                         used by hazard detection so that unused fields
//                         (e.g. garbage rs1 bits of a LUI) never cause a stall
package id_ex_stage_register_pkg;

    typedef enum logic [2:0] {
        ALU_R       = 3'b000,
        ALU_I_LOGIC = 3'b001,
        ALU_U       = 3'b010,
        ALU_LOAD    = 3'b011,
        ALU_S       = 3'b100,
        ALU_SB      = 3'b101,
        ALU_J       = 3'b110,
        ALU_JALR    = 3'b111
    } alu_op_e;

    typedef struct packed {
        logic       branch;
        logic       mem_read;
        logic       mem_to_reg;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
        logic [2:0] alu_op;
    } ctrl_t;

    localparam int CTRL_WIDTH = 9;

    function automatic logic uses_rs1(input logic [2:0] op);
        return !((op == ALU_U) || (op == ALU_J));
    endfunction

    function automatic logic uses_rs2(input logic [2:0] op);
        return (op == ALU_R) || (op == ALU_S) || (op == ALU_SB);
    endfunction

endpackage

// File: rtl/id_ex_stage_register_hazard_detect.sv
// Combinational load-use hazard detection.
//   valid_ex, mem_read_ex, rd_ex : instruction currently held in EX
//   valid_id, flush, alu_op, rs1_id, rs2_id : instruction currently in ID
//   stall : ID must hold for one cycle because EX is a load whose
//           destination is a source actually read by the ID instruction
module id_ex_stage_register_hazard_detect
    import id_ex_stage_register_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      valid_ex,
    input  logic                      mem_read_ex,
    input  logic [REG_ADDR_WIDTH-1:0] rd_ex,
    input  logic                      valid_id,
    input  logic                      flush,
    input  logic [2:0]                alu_op,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_id,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_id,
    output logic                      stall
);

    logic rs1_hit;
    logic rs2_hit;

    always_comb begin
        rs1_hit = uses_rs1(alu_op) && (rs1_id == rd_ex);
        rs2_hit = uses_rs2(alu_op) && (rs2_id == rd_ex);
        // x0 is hardwired zero, so a load into it never creates a dependency.
        // A flush kills the ID instruction, so there is nothing to protect.
        stall   = valid_ex && mem_read_ex && (rd_ex != '0) &&
                  valid_id && !flush && (rs1_hit || rs2_hit);
    end

endmodule

// File: rtl/id_ex_stage_register.sv
// ID/EX pipeline register of the 5-stage RISC-V core.
// Captures the decode control bundle and operands each cycle, inserting a
// bubble on flush, load-use stall, illegal encoding or an empty ID slot.
//   clk, reset           : clock, asynchronous active-high reset
//   Valid_i, Flush_i     : ID holds an instruction / squash it
//   *_i data + control   : decode-stage fields
//   Stall_o              : combinational load-use stall (freeze PC, IF/ID)
//   *_o, Valid_o         : registered EX-stage copies
//   Illegal_o            : sticky illegal-encoding flag
//   Stall_Count_o        : saturating count of load-use stall cycles
module id_ex_stage_register
    import id_ex_stage_register_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      Valid_i,
    input  logic                      Flush_i,
    input  logic [DATA_WIDTH-1:0]     PC_i,
    input  logic [DATA_WIDTH-1:0]     Read_Data_1_i,
    input  logic [DATA_WIDTH-1:0]     Read_Data_2_i,
    input  logic [DATA_WIDTH-1:0]     Immediate_i,
    input  logic [REG_ADDR_WIDTH-1:0] Rs1_i,
    input  logic [REG_ADDR_WIDTH-1:0] Rs2_i,
    input  logic [REG_ADDR_WIDTH-1:0] Rd_i,
    input  logic [3:0]                Funct_i,
    input  logic                      Branch_i,
    input  logic                      Mem_Read_i,
    input  logic                      Mem_to_Reg_i,
    input  logic                      Mem_Write_i,
    input  logic                      ALU_Src_i,
    input  logic                      Reg_Write_i,
    input  logic [2:0]                ALU_Op_i,
    output logic                      Stall_o,
    output logic                      Valid_o,
    output logic [DATA_WIDTH-1:0]     PC_o,
    output logic [DATA_WIDTH-1:0]     Read_Data_1_o,
    output logic [DATA_WIDTH-1:0]     Read_Data_2_o,
    output logic [DATA_WIDTH-1:0]     Immediate_o,
    output logic [REG_ADDR_WIDTH-1:0] Rs1_o,
    output logic [REG_ADDR_WIDTH-1:0] Rs2_o,
    output logic [REG_ADDR_WIDTH-1:0] Rd_o,
    output logic [3:0]                Funct_o,
    output logic                      Branch_o,
    output logic                      Mem_Read_o,
    output logic                      Mem_to_Reg_o,
    output logic                      Mem_Write_o,
    output logic                      ALU_Src_o,
    output logic                      Reg_Write_o,
    output logic [2:0]                ALU_Op_o,
    output logic                      Illegal_o,
    output logic [CNT_WIDTH-1:0]      Stall_Count_o
);

    ctrl_t                      ctrl_in;
    ctrl_t                      ctrl_reg;
    logic                       valid_reg;
    logic [DATA_WIDTH-1:0]      pc_reg;
    logic [DATA_WIDTH-1:0]      rd1_reg;
    logic [DATA_WIDTH-1:0]      rd2_reg;
    logic [DATA_WIDTH-1:0]      imm_reg;
    logic [REG_ADDR_WIDTH-1:0]  rs1_reg;
    logic [REG_ADDR_WIDTH-1:0]  rs2_reg;
    logic [REG_ADDR_WIDTH-1:0]  rd_reg;
    logic [3:0]                 funct_reg;
    logic                       illegal_reg;
    logic [CNT_WIDTH-1:0]       stall_count_reg;

    logic                       stall;
    logic                       illegal;
    logic                       load_en;

    assign ctrl_in = {Branch_i, Mem_Read_i, Mem_to_Reg_i, Mem_Write_i,
                      ALU_Src_i, Reg_Write_i, ALU_Op_i};

    id_ex_stage_register_hazard_detect #(
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_hazard (
        .valid_ex    (valid_reg),
        .mem_read_ex (ctrl_reg.mem_read),
        .rd_ex       (rd_reg),
        .valid_id    (Valid_i),
        .flush       (Flush_i),
        .alu_op      (ALU_Op_i),
        .rs1_id      (Rs1_i),
        .rs2_id      (Rs2_i),
        .stall       (stall)
    );

    // The decoder's default arm drives every control line high, so
    // read+write together marks an encoding it did not recognise.
    // stall already excludes Flush_i, giving flush > stall > illegal > invalid.
    always_comb begin
        illegal = Valid_i && Mem_Read_i && Mem_Write_i;
        load_en = Valid_i && !Flush_i && !stall && !illegal;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_reg <= 1'b0;
            ctrl_reg  <= '0;
            pc_reg    <= '0;
            rd1_reg   <= '0;
            rd2_reg   <= '0;
            imm_reg   <= '0;
            rs1_reg   <= '0;
            rs2_reg   <= '0;
            rd_reg    <= '0;
            funct_reg <= '0;
        end else if (load_en) begin
            valid_reg <= 1'b1;
            ctrl_reg  <= ctrl_in;
            pc_reg    <= PC_i;
            rd1_reg   <= Read_Data_1_i;
            rd2_reg   <= Read_Data_2_i;
            imm_reg   <= Immediate_i;
            rs1_reg   <= Rs1_i;
            rs2_reg   <= Rs2_i;
            rd_reg    <= Rd_i;
            funct_reg <= Funct_i;
        end else begin
            // Bubble: a fully zeroed slot, so EX cannot mistake it for a load.
            valid_reg <= 1'b0;
            ctrl_reg  <= '0;
            pc_reg    <= '0;
            rd1_reg   <= '0;
            rd2_reg   <= '0;
            imm_reg   <= '0;
            rs1_reg   <= '0;
            rs2_reg   <= '0;
            rd_reg    <= '0;
            funct_reg <= '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            illegal_reg     <= 1'b0;
            stall_count_reg <= '0;
        end else begin
            // A squashed illegal instruction was never going to execute.
            if (illegal && !Flush_i) begin
                illegal_reg <= 1'b1;
            end
            if (stall && (stall_count_reg != {CNT_WIDTH{1'b1}})) begin
                stall_count_reg <= stall_count_reg + CNT_WIDTH'(1);
            end
        end
    end

    assign Stall_o       = stall;
    assign Valid_o       = valid_reg;
    assign PC_o          = pc_reg;
    assign Read_Data_1_o = rd1_reg;
    assign Read_Data_2_o = rd2_reg;
    assign Immediate_o   = imm_reg;
    assign Rs1_o         = rs1_reg;
    assign Rs2_o         = rs2_reg;
    assign Rd_o          = rd_reg;
    assign Funct_o       = funct_reg;
    assign Branch_o      = ctrl_reg.branch;
    assign Mem_Read_o    = ctrl_reg.mem_read;
    assign Mem_to_Reg_o  = ctrl_reg.mem_to_reg;
    assign Mem_Write_o   = ctrl_reg.mem_write;
    assign ALU_Src_o     = ctrl_reg.alu_src;
    assign Reg_Write_o   = ctrl_reg.reg_write;
    assign ALU_Op_o      = ctrl_reg.alu_op;
    assign Illegal_o     = illegal_reg;
    assign Stall_Count_o = stall_count_reg;

endmodule

// File: tb/tb_id_ex_stage_register.sv
// Self-checking bench for id_ex_stage_register: a reset sequence, a table of
// directed vectors, a reset-during-stall sequence and randomized traffic,
// all compared against a behavioural model of the stage register.
module tb_id_ex_stage_register;

    typedef struct packed {
        logic        valid;
        logic        flush;
        logic [31:0] pc, rd1, rd2, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [3:0]  funct;
        logic        branch, mr, m2r, mw, alusrc, rw;
        logic [2:0]  aluop;
    } in_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc, rd1, rd2, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [3:0]  funct;
        logic        branch, mr, m2r, mw, alusrc, rw;
        logic [2:0]  aluop;
    } out_t;

    typedef struct {
        in_t  in;
        logic stall;
        logic valid;
        int   rd;
        logic ill;
        int   cnt;
        int   cnt2;
    } vec_t;

    localparam logic [2:0] OP_R = 3'd0, OP_I = 3'd1, OP_U = 3'd2, OP_LD = 3'd3,
                           OP_S = 3'd4, OP_SB = 3'd5, OP_J = 3'd6, OP_JR = 3'd7;
    // Which ALU classes read rs1 / rs2, indexed by class code.
    localparam logic [7:0] USE_RS1 = 8'b1011_1011;
    localparam logic [7:0] USE_RS2 = 8'b0011_0001;

    logic clk = 1'b0;
    logic reset = 1'b1;
    in_t  cur = '0;

    always #5 clk = ~clk;

    logic        Stall_o, Valid_o, Branch_o, Mem_Read_o, Mem_to_Reg_o, Mem_Write_o;
    logic        ALU_Src_o, Reg_Write_o, Illegal_o;
    logic [31:0] PC_o, Read_Data_1_o, Read_Data_2_o, Immediate_o;
    logic [4:0]  Rs1_o, Rs2_o, Rd_o;
    logic [3:0]  Funct_o;
    logic [2:0]  ALU_Op_o;
    logic [15:0] Stall_Count_o;

    logic        d2_stall, d2_valid, d2_branch, d2_mr, d2_m2r, d2_mw, d2_alusrc, d2_rw, d2_ill;
    logic [31:0] d2_pc, d2_rd1, d2_rd2, d2_imm;
    logic [4:0]  d2_rs1, d2_rs2, d2_rd;
    logic [3:0]  d2_funct;
    logic [2:0]  d2_aluop;
    logic [1:0]  d2_cnt;

    id_ex_stage_register u_dut (
        .clk(clk), .reset(reset), .Valid_i(cur.valid), .Flush_i(cur.flush),
        .PC_i(cur.pc), .Read_Data_1_i(cur.rd1), .Read_Data_2_i(cur.rd2),
        .Immediate_i(cur.imm), .Rs1_i(cur.rs1), .Rs2_i(cur.rs2), .Rd_i(cur.rd),
        .Funct_i(cur.funct), .Branch_i(cur.branch), .Mem_Read_i(cur.mr),
        .Mem_to_Reg_i(cur.m2r), .Mem_Write_i(cur.mw), .ALU_Src_i(cur.alusrc),
        .Reg_Write_i(cur.rw), .ALU_Op_i(cur.aluop),
        .Stall_o(Stall_o), .Valid_o(Valid_o), .PC_o(PC_o),
        .Read_Data_1_o(Read_Data_1_o), .Read_Data_2_o(Read_Data_2_o),
        .Immediate_o(Immediate_o), .Rs1_o(Rs1_o), .Rs2_o(Rs2_o), .Rd_o(Rd_o),
        .Funct_o(Funct_o), .Branch_o(Branch_o), .Mem_Read_o(Mem_Read_o),
        .Mem_to_Reg_o(Mem_to_Reg_o), .Mem_Write_o(Mem_Write_o),
        .ALU_Src_o(ALU_Src_o), .Reg_Write_o(Reg_Write_o), .ALU_Op_o(ALU_Op_o),
        .Illegal_o(Illegal_o), .Stall_Count_o(Stall_Count_o)
    );

    id_ex_stage_register #(.CNT_WIDTH(2)) u_dut2 (
        .clk(clk), .reset(reset), .Valid_i(cur.valid), .Flush_i(cur.flush),
        .PC_i(cur.pc), .Read_Data_1_i(cur.rd1), .Read_Data_2_i(cur.rd2),
        .Immediate_i(cur.imm), .Rs1_i(cur.rs1), .Rs2_i(cur.rs2), .Rd_i(cur.rd),
        .Funct_i(cur.funct), .Branch_i(cur.branch), .Mem_Read_i(cur.mr),
        .Mem_to_Reg_i(cur.m2r), .Mem_Write_i(cur.mw), .ALU_Src_i(cur.alusrc),
        .Reg_Write_i(cur.rw), .ALU_Op_i(cur.aluop),
        .Stall_o(d2_stall), .Valid_o(d2_valid), .PC_o(d2_pc),
        .Read_Data_1_o(d2_rd1), .Read_Data_2_o(d2_rd2),
        .Immediate_o(d2_imm), .Rs1_o(d2_rs1), .Rs2_o(d2_rs2), .Rd_o(d2_rd),
        .Funct_o(d2_funct), .Branch_o(d2_branch), .Mem_Read_o(d2_mr),
        .Mem_to_Reg_o(d2_m2r), .Mem_Write_o(d2_mw),
        .ALU_Src_o(d2_alusrc), .Reg_Write_o(d2_rw), .ALU_Op_o(d2_aluop),
        .Illegal_o(d2_ill), .Stall_Count_o(d2_cnt)
    );

    out_t dut_out;
    assign dut_out = {Valid_o, PC_o, Read_Data_1_o, Read_Data_2_o, Immediate_o,
                      Rs1_o, Rs2_o, Rd_o, Funct_o, Branch_o, Mem_Read_o,
                      Mem_to_Reg_o, Mem_Write_o, ALU_Src_o, Reg_Write_o, ALU_Op_o};

    int n_tests = 0;
    int n_fail  = 0;
    int n_step  = 0;

    // Behavioural model state: what EX should hold, sticky flag, stall total.
    out_t m_ex;
    logic m_ill;
    int   m_stalls;

    task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_ex = '0;
        m_ill = 1'b0;
        m_stalls = 0;
    endtask

    function automatic logic model_stall(input in_t v);
        logic hit1, hit2;
        hit1 = USE_RS1[v.aluop] && (v.rs1 == m_ex.rd);
        hit2 = USE_RS2[v.aluop] && (v.rs2 == m_ex.rd);
        return m_ex.valid && m_ex.mr && (m_ex.rd != 5'd0) && v.valid && !v.flush && (hit1 || hit2);
    endfunction

    function automatic int sat(input int x, input int max);
        return (x > max) ? max : x;
    endfunction

    // One clock of traffic: drive, check Stall_o, advance the model, check EX.
    task automatic step(input in_t v, output logic got_stall);
        logic exp_stall, illegal;
        cur = v;
        #1;
        exp_stall = model_stall(v);
        got_stall = Stall_o;
        check("stall", 192'(Stall_o), 192'(exp_stall));
        illegal = v.valid && v.mr && v.mw;
        if (illegal && !v.flush) m_ill = 1'b1;
        if (exp_stall) m_stalls++;
        if (v.flush || exp_stall || illegal || !v.valid) begin
            m_ex = '0;
        end else begin
            m_ex = '{valid: 1'b1, pc: v.pc, rd1: v.rd1, rd2: v.rd2, imm: v.imm,
                     rs1: v.rs1, rs2: v.rs2, rd: v.rd, funct: v.funct,
                     branch: v.branch, mr: v.mr, m2r: v.m2r, mw: v.mw,
                     alusrc: v.alusrc, rw: v.rw, aluop: v.aluop};
        end
        @(posedge clk);
        #1;
        check("ex_fields", 192'(dut_out), 192'(m_ex));
        check("illegal", 192'(Illegal_o), 192'(m_ill));
        check("count16", 192'(Stall_Count_o), 192'(sat(m_stalls, 65535)));
        check("count2", 192'(d2_cnt), 192'(sat(m_stalls, 3)));
        n_step++;
        $display("[TB] step %0d v=%0b fl=%0b op=%0d rs=%0d,%0d rd=%0d stall=%0b -> valid=%0b rd=%0d ill=%0b cnt=%0d",
                 n_step, v.valid, v.flush, v.aluop, v.rs1, v.rs2, v.rd, got_stall,
                 Valid_o, Rd_o, Illegal_o, Stall_Count_o);
    endtask

    function automatic in_t mk(input bit v, input bit fl, input logic [2:0] op,
                               input int rs1, input int rs2, input int rd,
                               input bit mr, input bit mw);
        in_t r;
        r.valid  = v;
        r.flush  = fl;
        r.pc     = 32'h1000 + 32'($urandom_range(0, 255)) * 4;
        r.rd1    = $urandom;
        r.rd2    = $urandom;
        r.imm    = $urandom;
        r.rs1    = 5'(rs1);
        r.rs2    = 5'(rs2);
        r.rd     = 5'(rd);
        r.funct  = 4'($urandom_range(0, 15));
        r.aluop  = op;
        r.mr     = mr;
        r.mw     = mw;
        r.m2r    = mr;
        r.branch = (op == OP_SB);
        r.alusrc = (op != OP_R);
        r.rw     = !(op == OP_S || op == OP_SB);
        return r;
    endfunction

    function automatic in_t mk_ill(input bit fl, input int rd);
        in_t r;
        r = mk(1'b1, fl, OP_JR, 8, 8, rd, 1'b1, 1'b1);
        r.branch = 1'b1;
        r.m2r = 1'b1;
        r.alusrc = 1'b1;
        r.rw = 1'b1;
        return r;
    endfunction

    function automatic vec_t row(input in_t i, input bit s, input bit v, input int rd,
                                 input bit ill, input int c, input int c2);
        vec_t r;
        r.in = i; r.stall = s; r.valid = v; r.rd = rd; r.ill = ill; r.cnt = c; r.cnt2 = c2;
        return r;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[$];
        logic s;
        in_t  v;

        // Reset held with a valid R-type in ID: everything stays a bubble.
        model_reset();
        cur = mk(1'b1, 1'b0, OP_R, 1, 2, 6, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_outs", 192'(dut_out), 192'(0));
        check("reset_ill", 192'(Illegal_o), 192'(0));
        check("reset_cnt", 192'(Stall_Count_o), 192'(0));
        check("reset_stall", 192'(Stall_o), 192'(0));
        reset = 1'b0;
        step(cur, s);
        check("first_valid", 192'(Valid_o), 192'(1));
        check("first_rd", 192'(Rd_o), 192'(6));

        // Directed vectors: {instr, Stall_o, Valid_o, Rd_o, Illegal_o, count16, count2}.
        tbl.push_back(row(mk(1, 0, OP_LD, 1, 0, 5, 1, 0), 0, 1, 5, 0, 0, 0)); // lw x5
        tbl.push_back(row(mk(1, 0, OP_R,  5, 1, 6, 0, 0), 1, 0, 0, 0, 1, 1)); // add x6,x5,x1 stalls
        tbl.push_back(row(mk(1, 0, OP_R,  5, 1, 6, 0, 0), 0, 1, 6, 0, 1, 1)); // add loads
        tbl.push_back(row(mk(1, 0, OP_LD, 1, 0, 0, 1, 0), 0, 1, 0, 0, 1, 1)); // lw x0
        tbl.push_back(row(mk(1, 0, OP_R,  0, 0, 6, 0, 0), 0, 1, 6, 0, 1, 1)); // add x6,x0,x0
        tbl.push_back(row(mk(1, 0, OP_LD, 2, 0, 7, 1, 0), 0, 1, 7, 0, 1, 1)); // lw x7
        tbl.push_back(row(mk(1, 0, OP_U,  7, 7, 7, 0, 0), 0, 1, 7, 0, 1, 1)); // lui x7
        tbl.push_back(row(mk(1, 0, OP_LD, 3, 0, 8, 1, 0), 0, 1, 8, 0, 1, 1)); // lw x8
        tbl.push_back(row(mk(1, 1, OP_S,  8, 8, 0, 0, 1), 0, 0, 0, 0, 1, 1)); // sw + flush over hazard
        tbl.push_back(row(mk(1, 0, OP_S,  2, 3, 0, 0, 1), 0, 1, 0, 0, 1, 1)); // sw
        tbl.push_back(row(mk_ill(1, 9),                   0, 0, 0, 0, 1, 1)); // illegal + flush
        tbl.push_back(row(mk_ill(0, 9),                   0, 0, 0, 1, 1, 1)); // illegal
        tbl.push_back(row(mk(0, 0, OP_R,  1, 2, 3, 0, 0), 0, 0, 0, 1, 1, 1)); // invalid slot
        tbl.push_back(row(mk(1, 0, OP_R,  1, 2, 10, 0, 0), 0, 1, 10, 1, 1, 1));
        for (int k = 0; k < 3; k++) begin
            tbl.push_back(row(mk(1, 0, OP_LD, 1, 0, 5, 1, 0), 0, 1, 5, 1, 1 + k, sat(1 + k, 3)));
            tbl.push_back(row(mk(1, 0, OP_R,  5, 1, 6, 0, 0), 1, 0, 0, 1, 2 + k, sat(2 + k, 3)));
        end
        tbl.push_back(row(mk(1, 0, OP_R, 5, 1, 6, 0, 0), 0, 1, 6, 1, 4, 3));

        foreach (tbl[i]) begin
            step(tbl[i].in, s);
            check("tbl_stall", 192'(s), 192'(tbl[i].stall));
            check("tbl_valid", 192'(Valid_o), 192'(tbl[i].valid));
            check("tbl_rd", 192'(Rd_o), 192'(tbl[i].rd));
            check("tbl_illegal", 192'(Illegal_o), 192'(tbl[i].ill));
            check("tbl_cnt16", 192'(Stall_Count_o), 192'(tbl[i].cnt));
            check("tbl_cnt2", 192'(d2_cnt), 192'(tbl[i].cnt2));
        end

        // Asynchronous reset while a load-use stall is being signalled.
        step(mk(1, 0, OP_LD, 1, 0, 5, 1, 0), s);
        cur = mk(1, 0, OP_R, 5, 1, 6, 0, 0);
        #1;
        check("midstall_stall", 192'(Stall_o), 192'(1));
        reset = 1'b1;
        #1;
        check("midstall_stall_drop", 192'(Stall_o), 192'(0));
        check("midstall_valid", 192'(Valid_o), 192'(0));
        check("midstall_outs", 192'(dut_out), 192'(0));
        check("midstall_ill", 192'(Illegal_o), 192'(0));
        check("midstall_cnt16", 192'(Stall_Count_o), 192'(0));
        check("midstall_cnt2", 192'(d2_cnt), 192'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();

        // Randomized traffic over a small register set to provoke hazards.
        for (int k = 0; k < 400; k++) begin
            logic [2:0] op;
            bit mr, mw;
            op = 3'($urandom_range(0, 7));
            mr = (op == OP_LD);
            mw = (op == OP_S);
            if ($urandom_range(0, 19) == 0) begin
                mr = 1'b1;
                mw = 1'b1;
            end
            v = mk($urandom_range(0, 7) != 0, $urandom_range(0, 7) == 0, op,
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), mr, mw);
            step(v, s);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
